// File: rtl/ad9708_sample_unpacker_if.sv
// -----------------------------------------------------------------------------
// ad9708_sample_unpacker_if
// AXI4-Stream word channel carrying packed DAC samples into the unpacker.
//   tdata  : four 8-bit samples, byte 0 is played first
//   tvalid : producer has a word
//   tready : unpacker FIFO can accept a word
//   tlast  : word closes a DMA frame
// Modports: master = stream producer, slave = unpacker.
// -----------------------------------------------------------------------------
interface ad9708_sample_unpacker_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ad9708_sample_unpacker.sv
// -----------------------------------------------------------------------------
// ad9708_sample_unpacker
// Buffers 32-bit stream words in a small FIFO and plays them out as 8-bit
// AD9708 samples, least-significant byte first, at one sample every
// rate_div+1 ACLK cycles while enabled.
//
// Parameters:
//   FIFO_DEPTH : word FIFO depth (power of two, at least 4)
//   DIV_W      : width of the rate divider
// Ports:
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   s_axis        : stream word input (slave modport)
//   enable        : playback enable
//   rate_div      : sample period minus one, in ACLK cycles
//   clr_underrun  : one-cycle clear of the sticky underrun flag
//   dac_data      : sample towards the DAC output stage
//   dac_valid     : one-cycle strobe for each real sample
//   underrun      : sticky flag, a sample was due while the FIFO was empty
//   frame_done    : one-cycle pulse on the last sample of a tlast word
//   fifo_level    : number of words stored
// Build option:
//   AD9708_MIDSCALE_IDLE_EN : when defined, dac_data returns to mid-scale
//   (8'h80) on underrun ticks and while disabled; otherwise it holds.
// -----------------------------------------------------------------------------
module ad9708_sample_unpacker #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   ad9708_sample_unpacker_if.slave       s_axis,
   input  logic                          enable,
   input  logic [DIV_W-1:0]              rate_div,
   input  logic                          clr_underrun,
   output logic [7:0]                    dac_data,
   output logic                          dac_valid,
   output logic                          underrun,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int              AW         = $clog2(FIFO_DEPTH);
   localparam int              LW         = AW + 1;
   localparam logic [LW-1:0]   LEVEL_FULL = LW'(FIFO_DEPTH);
   localparam logic [7:0]      MID_SCALE  = 8'h80;

`ifdef AD9708_MIDSCALE_IDLE_EN
   localparam bit MIDSCALE_IDLE = 1'b1;
`else
   localparam bit MIDSCALE_IDLE = 1'b0;
`endif

   // Pick one sample out of a packed word; index 0 is the low byte.
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
   endfunction

   // Storage and state
   logic [32:0]        mem_r [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_r;
   logic [AW-1:0]      rd_ptr_r;
   logic [LW-1:0]      level_r;
   logic [DIV_W-1:0]   cnt_r;
   logic [1:0]         byte_idx_r;
   logic [7:0]         dac_data_r;
   logic               dac_valid_r;
   logic               underrun_r;
   logic               frame_done_r;

   // Decoded per-cycle controls
   logic               ready_s;
   logic               push_s;
   logic               pop_s;
   logic               empty_s;
   logic               tick_s;
   logic               play_s;
   logic               starve_s;
   logic               last_byte_s;
   logic               drop_partial_s;
   logic [32:0]        head_s;
   logic [7:0]         head_byte_s;

   // Ready is decoded from the registered level only, so a full FIFO never
   // accepts a word even if it pops in the same cycle.
   assign ready_s       = (level_r != LEVEL_FULL);
   assign s_axis.tready = ready_s;
   assign push_s        = s_axis.tvalid && ready_s;

   // Derive tick, play/starve and pop decisions from registered state.
   always_comb begin
      empty_s        = (level_r == {LW{1'b0}});
      head_s         = mem_r[rd_ptr_r];
      head_byte_s    = byte_sel(head_s[31:0], byte_idx_r);
      last_byte_s    = (byte_idx_r == 2'd3);
      if (enable) begin
         tick_s         = (cnt_r == rate_div);
         drop_partial_s = 1'b0;
      end else begin
         tick_s         = 1'b0;
         // A word interrupted mid-play is discarded so re-enable starts aligned.
         drop_partial_s = (byte_idx_r != 2'd0) && !empty_s;
      end
      play_s   = tick_s && !empty_s;
      starve_s = tick_s && empty_s;
      pop_s    = (play_s && last_byte_s) || drop_partial_s;
   end

   // Rate divider: counts 0..rate_div while enabled, parked at zero otherwise.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (!enable) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (cnt_r == rate_div) begin
         cnt_r <= {DIV_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + DIV_W'(1);
      end
   end

   // Word storage; contents need no reset because the pointers define validity.
   always_ff @(posedge ACLK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {s_axis.tlast, s_axis.tdata};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Position of the next sample within the head word.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         byte_idx_r <= 2'd0;
      end else if (!enable) begin
         byte_idx_r <= 2'd0;
      end else if (play_s) begin
         byte_idx_r <= byte_idx_r + 2'd1;
      end else begin
         byte_idx_r <= byte_idx_r;
      end
   end

   // Registered DAC-side outputs.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         dac_data_r   <= MID_SCALE;
         dac_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         dac_valid_r  <= play_s;
         frame_done_r <= play_s && last_byte_s && head_s[32];
         if (play_s) begin
            dac_data_r <= head_byte_s;
         end else if (MIDSCALE_IDLE && (starve_s || !enable)) begin
            dac_data_r <= MID_SCALE;
         end else begin
            dac_data_r <= dac_data_r;
         end
      end
   end

   // Sticky underrun; a set in the same cycle as a clear takes priority.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         underrun_r <= 1'b0;
      end else if (starve_s) begin
         underrun_r <= 1'b1;
      end else if (clr_underrun) begin
         underrun_r <= 1'b0;
      end else begin
         underrun_r <= underrun_r;
      end
   end

   assign dac_data   = dac_data_r;
   assign dac_valid  = dac_valid_r;
   assign underrun   = underrun_r;
   assign frame_done = frame_done_r;
   assign fifo_level = level_r;

endmodule

// File: tb/tb_ad9708_sample_unpacker.sv
module tb_ad9708_sample_unpacker;

   localparam int DEPTH = 16;
   localparam int DW    = 16;
`ifdef AD9708_MIDSCALE_IDLE_EN
   localparam bit MIDSCALE = 1'b1;
`else
   localparam bit MIDSCALE = 1'b0;
`endif
   localparam logic [7:0] IDLE_B = MIDSCALE ? 8'h80 : 8'h44;

   logic            ACLK = 1'b0;
   logic            ARESETN;
   logic            enable;
   logic [DW-1:0]   rate_div;
   logic            clr_underrun;
   logic [7:0]      dac_data;
   logic            dac_valid;
   logic            underrun;
   logic            frame_done;
   logic [4:0]      fifo_level;

   ad9708_sample_unpacker_if axis_if();

   ad9708_sample_unpacker #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .s_axis       (axis_if),
      .enable       (enable),
      .rate_div     (rate_div),
      .clr_underrun (clr_underrun),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid),
      .underrun     (underrun),
      .frame_done   (frame_done),
      .fifo_level   (fifo_level)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model: a queue of pending samples -------------
   logic [8:0] mq[$];        // {last-of-frame, sample}
   int         m_en_n;       // enabled cycles since enable rose
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_fd;
   logic       m_ur;

   task automatic model_reset();
      mq.delete();
      m_en_n  = 0;
      m_data  = 8'h80;
      m_valid = 1'b0;
      m_fd    = 1'b0;
      m_ur    = 1'b0;
   endtask

   function automatic int m_level();
      return (mq.size() + 3) / 4;
   endfunction

   task automatic model_edge();
      bit         acc;
      bit         tick;
      bit         set_now;
      logic [8:0] b;
      acc     = axis_if.tvalid && (m_level() != DEPTH);
      m_valid = 1'b0;
      m_fd    = 1'b0;
      set_now = 1'b0;
      if (!enable) begin
         m_en_n = 0;
         while (mq.size() % 4 != 0) void'(mq.pop_front());
         if (MIDSCALE) m_data = 8'h80;
      end else begin
         tick = (m_en_n % (int'(rate_div) + 1)) == int'(rate_div);
         m_en_n++;
         if (tick && mq.size() > 0) begin
            b       = mq.pop_front();
            m_data  = b[7:0];
            m_valid = 1'b1;
            m_fd    = b[8];
         end else if (tick) begin
            set_now = 1'b1;
            if (MIDSCALE) m_data = 8'h80;
         end
      end
      if (set_now) m_ur = 1'b1;
      else if (clr_underrun) m_ur = 1'b0;
      if (acc) begin
         for (int k = 0; k < 4; k++)
            mq.push_back({(k == 3) ? axis_if.tlast : 1'b0, axis_if.tdata[8*k +: 8]});
      end
   endtask

   task automatic compare_model();
      check("dac_valid",  {31'd0, dac_valid},  {31'd0, m_valid});
      check("dac_data",   {24'd0, dac_data},   {24'd0, m_data});
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      check("underrun",   {31'd0, underrun},   {31'd0, m_ur});
      check("fifo_level", {27'd0, fifo_level}, m_level());
      check("tready",     {31'd0, axis_if.tready}, {31'd0, (m_level() != DEPTH)});
   endtask

   task automatic cycle();
      model_edge();
      @(posedge ACLK);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      ARESETN        = 1'b0;
      axis_if.tvalid = 1'b0;
      axis_if.tdata  = 32'd0;
      axis_if.tlast  = 1'b0;
      enable         = 1'b0;
      rate_div       = 16'd0;
      clr_underrun   = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      model_reset();
      compare_model();
   endtask

   // ---------------- directed vector table ------------------------------------
   typedef struct packed {
      logic        tvalid;
      logic [31:0] tdata;
      logic        tlast;
      logic        en;
      logic [15:0] rdiv;
      logic        clr;
      logic        e_valid;
      logic [7:0]  e_data;
      logic        e_fd;
      logic [4:0]  e_level;
      logic        e_ur;
   } vec_t;

   vec_t vt[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         acc_cnt;
      int         acc_at;
      bit         acc;
      int         en_start;
      int         vq[$];
      int         fq[$];
      logic [7:0] sq[$];
      int         prob;

      // byte order, frame_done, then underrun and clear priority
      vt[0] = '{1'b1, 32'h44332211, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 8'h80,  1'b0, 5'd1, 1'b0};
      vt[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 8'h11,  1'b0, 5'd1, 1'b0};
      vt[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 8'h22,  1'b0, 5'd1, 1'b0};
      vt[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 8'h33,  1'b0, 5'd1, 1'b0};
      vt[4] = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 8'h44,  1'b1, 5'd0, 1'b0};
      vt[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd0, 1'b0, 1'b0, IDLE_B, 1'b0, 5'd0, 1'b1};
      vt[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 16'd0, 1'b1, 1'b0, IDLE_B, 1'b0, 5'd0, 1'b1};
      vt[7] = '{1'b0, 32'h0,        1'b0, 1'b0, 16'd0, 1'b1, 1'b0, IDLE_B, 1'b0, 5'd0, 1'b0};

      do_reset();
      check("reset_dac_data", {24'd0, dac_data}, 32'h80);
      check("reset_tready", {31'd0, axis_if.tready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         axis_if.tvalid = vt[i].tvalid;
         axis_if.tdata  = vt[i].tdata;
         axis_if.tlast  = vt[i].tlast;
         enable         = vt[i].en;
         rate_div       = vt[i].rdiv;
         clr_underrun   = vt[i].clr;
         cycle();
         check($sformatf("vec%0d_valid", i), {31'd0, dac_valid},  {31'd0, vt[i].e_valid});
         check($sformatf("vec%0d_data", i),  {24'd0, dac_data},   {24'd0, vt[i].e_data});
         check($sformatf("vec%0d_fd", i),    {31'd0, frame_done}, {31'd0, vt[i].e_fd});
         check($sformatf("vec%0d_level", i), {27'd0, fifo_level}, {27'd0, vt[i].e_level});
         check($sformatf("vec%0d_ur", i),    {31'd0, underrun},   {31'd0, vt[i].e_ur});
      end
      clr_underrun = 1'b0;

      // rate: rate_div=3 with a continuously full FIFO
      do_reset();
      rate_div       = 16'd3;
      axis_if.tvalid = 1'b1;
      axis_if.tlast  = 1'b1;
      repeat (20) begin
         axis_if.tdata = $urandom;
         cycle();
      end
      enable   = 1'b1;
      en_start = cyc;
      repeat (80) begin
         axis_if.tdata = $urandom;
         cycle();
         if (dac_valid)  vq.push_back(cyc);
         if (frame_done) fq.push_back(cyc);
      end
      check("rate_valid_count", vq.size(), 32'd20);
      check("rate_frame_count", fq.size(), 32'd5);
      if (vq.size() > 0) check("rate_first_tick", vq[0], en_start + 4);
      if (fq.size() > 0) check("rate_first_pop", fq[0], en_start + 16);
      for (int i = 1; i < vq.size(); i++) check("rate_sample_period", vq[i] - vq[i-1], 32'd4);
      for (int i = 1; i < fq.size(); i++) check("rate_word_period", fq[i] - fq[i-1], 32'd16);

      // full FIFO: 16 accepted while disabled, 17th after the first pop
      do_reset();
      axis_if.tvalid = 1'b1;
      acc_cnt        = 0;
      for (int i = 0; i < 20; i++) begin
         axis_if.tdata = 32'h1000_0000 + acc_cnt;
         acc           = axis_if.tready;
         cycle();
         if (acc) acc_cnt++;
      end
      check("full_accept_count", acc_cnt, 32'd16);
      check("full_tready", {31'd0, axis_if.tready}, 32'd0);
      check("full_level", {27'd0, fifo_level}, 32'd16);
      enable = 1'b1;
      acc_at = -1;
      for (int i = 0; i < 12 && acc_cnt < 17; i++) begin
         axis_if.tdata = 32'h1000_0000 + acc_cnt;
         acc           = axis_if.tready;
         cycle();
         if (acc) begin
            acc_cnt++;
            acc_at = i;
         end
      end
      check("word17_accepted", acc_cnt, 32'd17);
      check("word17_accept_cycle", acc_at, 32'd4);
      axis_if.tvalid = 1'b0;
      repeat (70) cycle();

      // disable mid-word, then resume on a word boundary
      do_reset();
      axis_if.tvalid = 1'b1;
      axis_if.tdata  = 32'hDDCCBBAA;
      cycle();
      axis_if.tvalid = 1'b0;
      enable         = 1'b1;
      cycle();
      cycle();
      check("mid_second_sample", {24'd0, dac_data}, 32'hBB);
      check("mid_level_before", {27'd0, fifo_level}, 32'd1);
      enable = 1'b0;
      cycle();
      check("mid_level_dropped", {27'd0, fifo_level}, 32'd0);
      axis_if.tvalid = 1'b1;
      axis_if.tdata  = 32'h04030201;
      axis_if.tlast  = 1'b1;
      cycle();
      axis_if.tvalid = 1'b0;
      enable         = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (dac_valid) sq.push_back(dac_data);
      end
      check("resume_count", sq.size(), 32'd4);
      for (int i = 0; i < 4 && i < sq.size(); i++)
         check($sformatf("resume_sample%0d", i), {24'd0, sq[i]}, i + 1);

      // asynchronous reset mid-stream
      do_reset();
      axis_if.tvalid = 1'b1;
      axis_if.tlast  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         axis_if.tdata = 32'hA0A1A2A3 + i;
         cycle();
      end
      axis_if.tvalid = 1'b0;
      enable         = 1'b1;
      cycle();
      cycle();
      check("pre_reset_valid", {31'd0, dac_valid}, 32'd1);
      #2;
      ARESETN = 1'b0;
      #1;
      check("async_rst_level", {27'd0, fifo_level}, 32'd0);
      check("async_rst_data", {24'd0, dac_data}, 32'h80);
      check("async_rst_valid", {31'd0, dac_valid}, 32'd0);
      check("async_rst_fd", {31'd0, frame_done}, 32'd0);
      check("async_rst_ur", {31'd0, underrun}, 32'd0);
      @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("no_valid_after_reset", {31'd0, dac_valid}, 32'd0);
      end

      // randomized traffic against the sample-queue model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         case ((i / 500) % 3)
            0:       prob = 50;
            1:       prob = 5;
            default: prob = 1;
         endcase
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         if (!enable && $urandom_range(0, 3) == 0) rate_div = 16'($urandom_range(0, 3));
         axis_if.tvalid = ($urandom_range(0, 99) < prob);
         axis_if.tdata  = $urandom;
         axis_if.tlast  = 1'($urandom_range(0, 1));
         clr_underrun   = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
